// File: rtl/modulo_transmissor_ataque_pkg.sv
// Shared definitions for the attack link: FSM states, frame sizes, error codes
// and the mapping from a (col, lin) shot to its bit in the 35-cell board mask.
// Latency: n/a. Backpressure: n/a.
package modulo_transmissor_ataque_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_TX        = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_RX        = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int TX_BITS     = 9;   // start, 6 coord bits, parity, stop
  localparam int RX_BITS     = 4;   // start, h, ~h, stop
  localparam int N_CELLS     = 35;
  localparam int MATRIX_COLS = 5;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_COORD  = 2'b01;
  localparam logic [1:0] ERR_REPEAT = 2'b10;
  localparam logic [1:0] ERR_LINK   = 2'b11;

  localparam logic [5:0] HIT_MAX = 6'd35;

  // Board matrix is stored line 0 first in the top bits: cell (0,0) is bit 34.
  // Only meaningful for in-range coordinates.
  function automatic logic [5:0] cell_idx(input logic [2:0] col, input logic [2:0] lin);
    logic [5:0] col_w;
    logic [5:0] lin_w;
    col_w = {3'b000, col};
    lin_w = {3'b000, lin};
    return 6'(N_CELLS - 1) - (lin_w * 6'(MATRIX_COLS) + col_w);
  endfunction

endpackage

// File: rtl/modulo_transmissor_ataque_rx.sv
// Reply receiver: 2-flop synchroniser on rx_resp, mid-bit sampler and 4-bit reply check.
// Latency: done pulses in the last cycle of the (synchronised) stop bit, 4*BIT_TICKS cycles after arm.
// Backpressure: none; arm restarts the receiver, results are valid only while done is high.
// Ports: clk/clr (async, active-low); rx_resp raw serial in; arm marks the start-bit detect
//        cycle; rx_low synchronised line level (inverted); done/ok/hit reply outcome.
module modulo_rx_resposta
  import modulo_transmissor_ataque_pkg::*;
#(
  parameter int BIT_TICKS = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic rx_resp,
  input  logic arm,
  output logic rx_low,
  output logic done,
  output logic ok,
  output logic hit
);

  localparam int TW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(BIT_TICKS / 2);

  logic [1:0]    sync_q, sync_d;
  logic          active_q, active_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    bit_q, bit_d;
  logic [3:0]    samp_q, samp_d;

  always_comb begin
    sync_d   = {sync_q[0], rx_resp};
    active_d = active_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    samp_d   = samp_q;
    done     = 1'b0;

    if (arm) begin
      // The detect cycle itself counts as tick 0 of the start bit.
      active_d = 1'b1;
      tick_d   = TW'(1);
      bit_d    = 2'd0;
      samp_d   = 4'd0;
    end else if (active_q) begin
      if (tick_q == TICK_MID) begin
        samp_d = {samp_q[2:0], sync_q[1]};
      end
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (bit_q == 2'(RX_BITS - 1)) begin
          active_d = 1'b0;
          done     = 1'b1;
        end else begin
          bit_d = bit_q + 2'd1;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    // Use the next-state samples so BIT_TICKS=2 (mid == last tick) still sees the stop bit.
    ok     = (samp_d[3] == 1'b0) && (samp_d[2] != samp_d[1]) && samp_d[0];
    hit    = samp_d[2];
    rx_low = ~sync_q[1];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q   <= 2'b11;
      active_q <= 1'b0;
      tick_q   <= '0;
      bit_q    <= 2'd0;
      samp_q   <= 4'd0;
    end else begin
      sync_q   <= sync_d;
      active_q <= active_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      samp_q   <= samp_d;
    end
  end

endmodule

// File: rtl/modulo_transmissor_ataque.sv
// Attacker end of the attack link: validate a shot, reject repeats, serialise it, decode the reply.
// Latency: rejected shot 2 cycles; valid shot 1 + 9*BIT_TICKS + reply wait + 4*BIT_TICKS + 1 cycles.
// Backpressure: busy high from accepted send until result_valid; send edges while busy are dropped.
// Ports: clk, clr (async active-low); at_coord {col,lin}; send level; new_game; rx_resp serial in;
//        tx_serial serial out; busy; result_valid pulse; hit; err_code; hit_count (saturating).
module modulo_transmissor_ataque
  import modulo_transmissor_ataque_pkg::*;
#(
  parameter int BIT_TICKS     = 4,
  parameter int TIMEOUT_TICKS = 255,
  parameter int N_COL         = 5,
  parameter int N_LIN         = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [5:0] at_coord,
  input  logic       send,
  input  logic       new_game,
  input  logic       rx_resp,
  output logic       tx_serial,
  output logic       busy,
  output logic       result_valid,
  output logic       hit,
  output logic [1:0] err_code,
  output logic [5:0] hit_count
);

  localparam int TW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
  localparam int WW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_TICKS - 1);

  state_e              state_q, state_d;
  logic                send_prev_q, send_prev_d;
  logic [5:0]          coord_q, coord_d;
  logic [N_CELLS-1:0]  mask_q, mask_d;
  logic [5:0]          count_q, count_d;
  logic                hit_q, hit_d;
  logic [1:0]          err_q, err_d;
  logic [8:0]          frame_q, frame_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [3:0]          bit_q, bit_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic                tx_q, tx_d;

  logic       start;
  logic       rx_arm;
  logic       rx_low;
  logic       rx_done;
  logic       rx_ok;
  logic       rx_hit;
  logic [2:0] col;
  logic [2:0] lin;
  logic [5:0] idx;

  modulo_rx_resposta #(
    .BIT_TICKS(BIT_TICKS)
  ) u_rx (
    .clk    (clk),
    .clr    (clr),
    .rx_resp(rx_resp),
    .arm    (rx_arm),
    .rx_low (rx_low),
    .done   (rx_done),
    .ok     (rx_ok),
    .hit    (rx_hit)
  );

  assign col = coord_q[5:3];
  assign lin = coord_q[2:0];
  assign idx = cell_idx(col, lin);

  always_comb begin
    state_d     = state_q;
    send_prev_d = send;
    coord_d     = coord_q;
    mask_d      = mask_q;
    count_d     = count_q;
    hit_d       = hit_q;
    err_d       = err_q;
    frame_d     = frame_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    wait_d      = wait_q;
    rx_arm      = 1'b0;
    start       = send & ~send_prev_q;

    case (state_q)
      ST_IDLE: begin
        // Clear takes effect before CHECK reads the mask, so a same-cycle shot sees a fresh board.
        if (new_game) begin
          mask_d  = '0;
          count_d = '0;
        end
        if (start) begin
          coord_d = at_coord;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (int'(col) >= N_COL || int'(lin) >= N_LIN) begin
          err_d   = ERR_COORD;
          hit_d   = 1'b0;
          state_d = ST_DONE;
        end else if (mask_q[idx]) begin
          err_d   = ERR_REPEAT;
          hit_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          mask_d[idx] = 1'b1;
          frame_d     = {1'b0, coord_q, ^coord_q, 1'b1};
          tick_d      = '0;
          bit_d       = 4'd0;
          state_d     = ST_TX;
        end
      end

      ST_TX: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (bit_q == 4'(TX_BITS - 1)) begin
            wait_d  = '0;
            state_d = ST_WAIT_RESP;
          end else begin
            bit_d   = bit_q + 4'd1;
            frame_d = {frame_q[7:0], 1'b1};
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      ST_WAIT_RESP: begin
        if (rx_low) begin
          rx_arm  = 1'b1;
          state_d = ST_RX;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = ERR_LINK;
          hit_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      ST_RX: begin
        if (rx_done) begin
          err_d   = rx_ok ? ERR_OK : ERR_LINK;
          hit_d   = rx_ok & rx_hit;
          state_d = ST_DONE;
          if (rx_ok && rx_hit && count_q < HIT_MAX) begin
            count_d = count_q + 6'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered line driver: follows the MSB of the frame only while transmitting.
    tx_d = (state_d == ST_TX) ? frame_d[8] : 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      send_prev_q <= 1'b0;
      coord_q     <= 6'd0;
      mask_q      <= '0;
      count_q     <= 6'd0;
      hit_q       <= 1'b0;
      err_q       <= ERR_OK;
      frame_q     <= 9'h1FF;
      tick_q      <= '0;
      bit_q       <= 4'd0;
      wait_q      <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      send_prev_q <= send_prev_d;
      coord_q     <= coord_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      wait_q      <= wait_d;
      tx_q        <= tx_d;
    end
  end

  assign tx_serial    = tx_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign result_valid = (state_q == ST_DONE);
  assign hit          = hit_q;
  assign err_code     = err_q;
  assign hit_count    = count_q;

endmodule

// File: tb/tb_modulo_transmissor_ataque.sv
// Bench for the attack link transmitter: directed cases plus randomized shots against a board model.
// Latency: n/a. Backpressure: n/a.
module tb_modulo_transmissor_ataque;

  localparam int BT  = 4;
  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       clr;
  logic [5:0] at_coord;
  logic       send;
  logic       new_game;
  logic       rx_resp;
  logic       tx_serial;
  logic       busy;
  logic       result_valid;
  logic       hit;
  logic [1:0] err_code;
  logic [5:0] hit_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference board: one flag per cell, indexed lin*5+col.
  bit model_shot[35];
  int model_hits;

  always #5 clk = ~clk;

  modulo_transmissor_ataque #(
    .BIT_TICKS    (BT),
    .TIMEOUT_TICKS(TMO),
    .N_COL        (5),
    .N_LIN        (7)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .at_coord    (at_coord),
    .send        (send),
    .new_game    (new_game),
    .rx_resp     (rx_resp),
    .tx_serial   (tx_serial),
    .busy        (busy),
    .result_valid(result_valid),
    .hit         (hit),
    .err_code    (err_code),
    .hit_count   (hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 35; i++) model_shot[i] = 1'b0;
    model_hits = 0;
  endtask

  // mode: 0 reply hit, 1 reply miss, 2 reply with bad check bit, 3 no reply.
  task automatic shot(input logic [5:0] c, input int mode, input bit newg, input bit glitch,
                      input string tag);
    int         col, lin, rel, exp_err, exp_hit, d;
    logic [8:0] fr, exp_fr;
    logic [3:0] reply;
    bit         seen;
    col = int'(c[5:3]);
    lin = int'(c[2:0]);
    @(negedge clk);
    at_coord = c;
    send     = 1'b1;
    new_game = newg;
    if (newg) model_clear();
    @(negedge clk);
    new_game = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    if (col >= 5 || lin >= 7 || model_shot[lin*5 + col]) begin
      exp_err = (col >= 5 || lin >= 7) ? 1 : 2;
      exp_hit = 0;
      chk({tag, ".tx_idle0"}, tx_serial, 1);
      @(negedge clk);
      chk({tag, ".tx_idle1"}, tx_serial, 1);
      seen = (result_valid === 1'b1);
    end else begin
      model_shot[lin*5 + col] = 1'b1;
      @(negedge clk);
      chk({tag, ".start_lat"}, tx_serial, 0);
      rel = 0;
      repeat (BT/2) @(negedge clk);
      rel += BT/2;
      fr[8] = tx_serial;
      for (int i = 7; i >= 0; i--) begin
        if (glitch && i == 5) begin
          @(negedge clk); send = 1'b0; rx_resp = 1'b0;
          @(negedge clk); send = 1'b1; rx_resp = 1'b1;
          repeat (BT - 2) @(negedge clk);
        end else begin
          repeat (BT) @(negedge clk);
        end
        rel += BT;
        fr[i] = tx_serial;
      end
      exp_fr = {1'b0, c, ^c, 1'b1};
      chk({tag, ".frame"}, fr, exp_fr);
      chk({tag, ".busy_tx"}, busy, 1);
      seen = 1'b0;
      if (mode == 3) begin
        exp_err = 3;
        exp_hit = 0;
        while (!seen && rel < 9*BT + TMO + 50) begin
          @(negedge clk);
          rel++;
          if (result_valid === 1'b1) seen = 1'b1;
        end
        chk({tag, ".timeout_lat"}, rel, 9*BT + TMO);
      end else begin
        exp_hit = (mode == 0) ? 1 : 0;
        exp_err = (mode == 2) ? 3 : 0;
        if (mode == 2) exp_hit = 0;
        reply = {1'b0, (mode == 0), (mode == 2) ? (mode == 0) : !(mode == 0), 1'b1};
        d = $urandom_range(0, 12);
        repeat (9*BT + d - rel) @(negedge clk);
        for (int k = 3; k >= 0; k--) begin
          rx_resp = reply[k];
          repeat (BT) @(negedge clk);
        end
        rx_resp = 1'b1;
        for (int w = 0; w < 40 && !seen; w++) begin
          if (result_valid === 1'b1) seen = 1'b1;
          else @(negedge clk);
        end
      end
      if (exp_hit == 1 && model_hits < 35) model_hits++;
    end
    chk({tag, ".valid"}, result_valid, seen ? 1 : 0);
    chk({tag, ".seen"}, seen, 1);
    chk({tag, ".err"}, err_code, exp_err);
    chk({tag, ".hit"}, hit, exp_hit);
    chk({tag, ".count"}, hit_count, model_hits);
    chk({tag, ".busy_done"}, busy, 0);
    @(negedge clk);
    chk({tag, ".pulse"}, result_valid, 0);
    send = 1'b0;
    if (glitch) begin
      seen = 1'b0;
      repeat (50) begin
        @(negedge clk);
        if (tx_serial !== 1'b1 || busy !== 1'b0) seen = 1'b1;
      end
      chk({tag, ".single_frame"}, seen, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] c;
    int         r;
    clr      = 1'b0;
    at_coord = 6'd0;
    send     = 1'b0;
    new_game = 1'b0;
    rx_resp  = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst.tx", tx_serial, 1);
    chk("rst.busy", busy, 0);
    chk("rst.valid", result_valid, 0);
    chk("rst.hit", hit, 0);
    chk("rst.err", err_code, 0);
    chk("rst.count", hit_count, 0);
    clr = 1'b1;
    repeat (2) @(negedge clk);

    shot(6'b010_011, 0, 1'b0, 1'b0, "t1_hit");
    shot(6'b101_000, 0, 1'b0, 1'b0, "t2_badcol");
    shot(6'b001_111, 0, 1'b0, 1'b0, "t2_badlin");
    shot(6'b010_011, 0, 1'b0, 1'b0, "t3_repeat");
    shot(6'b010_011, 1, 1'b1, 1'b0, "t3_newgame");
    shot(6'b100_110, 3, 1'b0, 1'b0, "t4_timeout");
    shot(6'b100_110, 0, 1'b0, 1'b0, "t4_retry");
    shot(6'b000_000, 2, 1'b0, 1'b1, "t5_badchk");
    shot(6'b011_101, 0, 1'b0, 1'b0, "t6_prehit");

    // Reset in the middle of a frame.
    @(negedge clk);
    at_coord = 6'b001_010;
    send     = 1'b1;
    repeat (8) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("t6.tx", tx_serial, 1);
    chk("t6.busy", busy, 0);
    chk("t6.count", hit_count, 0);
    @(negedge clk);
    send = 1'b0;
    clr  = 1'b1;
    model_clear();
    @(negedge clk);
    shot(6'b001_010, 0, 1'b0, 1'b0, "t6_after");

    for (int n = 0; n < 30; n++) begin
      c[5:3] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      c[2:0] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 6)) : 3'd7;
      r = $urandom_range(0, 15);
      shot(c, (r == 0) ? 3 : (r % 3), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
           $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
